// File: rtl/host_bus_slave.sv
// Host parallel-bus responder: 64-bit parameter bank written as lo/hi halves,
// plus a CTRL/STATUS/COUNT/ID window. Each completed hi write is handed to the core as a commit pulse.
module host_bus_slave #(
    parameter int          NUM_PARAMS = 8,
    parameter logic [9:0]  CTRL_BASE  = 10'h300,
    parameter logic [31:0] ID_VALUE   = 32'h4D41_4701
) (
    input  logic        BCLK,
    input  logic        nReset,
    input  logic [9:0]  Address,
    input  logic        nCS,
    input  logic        nRD,
    input  logic [3:0]  nWR,
    inout  logic [31:0] Data,
    input  logic        Busy,
    output logic        Run,
    output logic        SoftClr,
    output logic        ParamWe,
    output logic [5:0]  ParamIdx,
    output logic [63:0] ParamData
);

    localparam int IDX_W       = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
    localparam int SLOTS       = 1 << IDX_W;
    localparam int PARAM_BYTES = 8 * NUM_PARAMS;
    localparam logic [7:0] CTRL_W   = CTRL_BASE[9:2];
    localparam logic [7:0] STATUS_W = CTRL_W + 8'd1;
    localparam logic [7:0] COUNT_W  = CTRL_W + 8'd2;
    localparam logic [7:0] ID_W     = CTRL_W + 8'd3;

    logic [3:0]       nWrQ;
    logic [3:0]       wrLanes;
    logic             wrEvent;
    logic             inParam;
    logic             half;
    logic [5:0]       idx;
    logic [IDX_W-1:0] slot;
    logic             ctrlSel;
    logic             stgHit;
    logic [31:0]      slotLo [SLOTS];
    logic [31:0]      slotHi [SLOTS];
    logic [31:0]      stgLo;
    logic             stgValid;
    logic [5:0]       stgIdx;
    logic [15:0]      commitCount;
    logic [31:0]      newHi;
    logic [31:0]      newLo;
    logic [31:0]      rdNext;
    logic [31:0]      rdData;
    logic             unusedAddr;

    function automatic logic [31:0] byteMerge(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [3:0]  lanes);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) m[8*i +: 8] = din[8*i +: 8];
        return m;
    endfunction

    // A lane only triggers on its falling strobe edge, so held strobes write once.
    assign wrLanes    = nCS ? 4'b0000 : (nWrQ & ~nWR);
    assign wrEvent    = |wrLanes;
    assign inParam    = ({22'b0, Address} < PARAM_BYTES);
    assign half       = Address[2];
    assign idx        = Address[8:3];
    assign slot       = Address[IDX_W+2:3];
    assign ctrlSel    = (Address[9:2] == CTRL_W);
    assign stgHit     = stgValid && (stgIdx == idx);
    assign newHi      = byteMerge(slotHi[slot], Data, wrLanes);
    assign newLo      = stgHit ? stgLo : slotLo[slot];
    assign unusedAddr = ^Address[1:0];

    always_ff @(posedge BCLK) begin
        nWrQ <= nWR;
    end

    always_ff @(posedge BCLK) begin
        if (!nReset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slotLo[i] <= '0;
                slotHi[i] <= '0;
            end
            stgLo       <= '0;
            stgValid    <= 1'b0;
            stgIdx      <= '0;
            commitCount <= '0;
            Run         <= 1'b0;
            SoftClr     <= 1'b0;
            ParamWe     <= 1'b0;
            ParamIdx    <= '0;
            ParamData   <= '0;
        end else begin
            ParamWe <= 1'b0;
            SoftClr <= 1'b0;
            if (wrEvent && inParam && !half) begin
                stgLo    <= byteMerge(stgLo, Data, wrLanes);
                stgValid <= 1'b1;
                stgIdx   <= idx;
            end else if (wrEvent && inParam) begin
                slotHi[slot] <= newHi;
                slotLo[slot] <= newLo;
                // Staging survives a hi write to a different slot.
                if (stgHit) stgValid <= 1'b0;
                ParamWe     <= 1'b1;
                ParamIdx    <= idx;
                ParamData   <= {newHi, newLo};
                commitCount <= commitCount + 16'd1;
            end else if (wrEvent && ctrlSel && wrLanes[0]) begin
                Run <= Data[0];
                if (Data[1]) begin
                    SoftClr  <= 1'b1;
                    stgValid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rdNext = '0;
        if (inParam)
            rdNext = half ? slotHi[slot] : slotLo[slot];
        else if (Address[9:2] == CTRL_W)
            rdNext = {31'b0, Run};
        else if (Address[9:2] == STATUS_W)
            rdNext = {30'b0, stgValid, Busy};
        else if (Address[9:2] == COUNT_W)
            rdNext = {16'b0, commitCount};
        else if (Address[9:2] == ID_W)
            rdNext = ID_VALUE;
    end

    // Read stage: registered from pre-write state, so a same-cycle write is not visible.
    always_ff @(posedge BCLK) begin
        if (!nReset) rdData <= '0;
        else         rdData <= rdNext;
    end

    assign Data = (nReset && !nCS && !nRD) ? rdData : 32'hzzzz_zzzz;

endmodule
